// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;
  localparam int POP_W      = 64;

  function automatic int popcount(input logic [POP_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_W; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/rf_sb_core.sv
// Busy scoreboard: issue reserves a destination, writeback releases it.
module rf_sb_core
  import rf_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic             rsv_zero, rsv_acc, clr_hit;
  logic [DEPTH-1:0] busy_nxt;

  assign rsv_zero  = (ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_ADDR));
  // A write releasing the same register makes room for the new producer.
  assign rsv_ready = !busy[rsv_addr] || (we && (wa == rsv_addr));
  assign rsv_acc   = rsv_valid && rsv_ready && !rsv_zero;
  assign clr_hit   = we && busy[wa];

  // Set is applied after clear so a same-register reserve wins.
  always_comb begin
    busy_nxt = busy;
    if (we)      busy_nxt[wa]       = 1'b0;
    if (rsv_acc) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + (ADDR_W+1)'(rsv_acc) - (ADDR_W+1)'(clr_hit);
    end
  end
endmodule

// File: rtl/rf_scoreboard_mp.sv
// Multi-read-port register file with write bypass and a busy scoreboard.
module rf_scoreboard_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NREAD*ADDR_W-1:0]  ra,
  output logic [NREAD*DATA_W-1:0]  rd,
  output logic [NREAD-1:0]         rd_busy,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wz;

  assign wz = (ZERO_REG != 0) && (wa == ADDR_W'(ZERO_ADDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (we && !wz) begin
      mem[wa] <= wd;
    end
  end

  rf_sb_core #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wa        (wa),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ai;
    logic              hit, zr;
    assign ai = ra[i*ADDR_W +: ADDR_W];
    assign hit = (BYPASS != 0) && we && (wa == ai);
    assign zr  = (ZERO_REG != 0) && (ai == ADDR_W'(ZERO_ADDR));
    // rst_n masks a bypassed write so all ports read 0 during reset.
    assign rd[i*DATA_W +: DATA_W] = (!rst_n || zr) ? '0 : hit ? wd : mem[ai];
    assign rd_busy[i] = busy[ai] && !hit && !zr;
  end
endmodule
